// File: rtl/bsg_async_fifo_wr_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-side arbiter.
// Contents: state_e (arbiter state), tag_width() (requester-id field width,
// never below 1 bit).
package bsg_async_fifo_wr_arb_pkg;

    typedef enum logic {
        e_idle = 1'b0,
        e_lock = 1'b1
    } state_e;

    // Width of a requester id; a single requester still gets a 1-bit field.
    function automatic int unsigned tag_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_arb_rr_pick.sv
// Combinational rotate-priority picker.
// Ports:
//   reqs_i  request vector
//   ptr_i   highest-priority index; scan runs ptr_i, ptr_i+1, ... wrapping
//   v_o     some request present
//   id_o    index of the chosen request (0 when v_o=0)
module bsg_arb_rr_pick
    import bsg_async_fifo_wr_arb_pkg::*;
#(
    parameter int unsigned reqs_p = 4
) (
    input  logic [reqs_p-1:0]                 reqs_i,
    input  logic [tag_width(reqs_p)-1:0]      ptr_i,
    output logic                              v_o,
    output logic [tag_width(reqs_p)-1:0]      id_o
);

    localparam int unsigned tag_width_lp = tag_width(reqs_p);

    int unsigned idx;

    // Scan from the lowest priority upward so the last hit is the winner.
    always_comb begin
        v_o  = 1'b0;
        id_o = '0;
        idx  = 0;
        for (int unsigned i = 0; i < reqs_p; i++) begin
            idx = 32'(ptr_i) + (reqs_p - 1 - i);
            if (idx >= reqs_p) begin
                idx = idx - reqs_p;
            end
            if (reqs_i[tag_width_lp'(idx)]) begin
                v_o  = 1'b1;
                id_o = tag_width_lp'(idx);
            end
        end
    end

endmodule

// File: rtl/bsg_async_fifo_wr_arb.sv
// Round-robin write-side arbiter feeding one bsg_async_fifo enqueue port.
// Packets framed by last_i are never interleaved: the grant locks to the
// winner until its last beat. The winner id rides in the top bits of the
// FIFO word.
// Ports:
//   clk_i, reset_i     FIFO write clock, synchronous active-high reset
//   v_i, data_i, last_i, ready_o   per-requester valid/ready beat interface
//   w_enq_o, w_data_o, w_full_i    FIFO enqueue side
//   lock_v_o, lock_id_o            packet-in-progress status
//   stall_cnt_o        only with BSG_ASYNC_FIFO_WR_ARB_STALL_CNT_EN defined:
//                      saturating count of cycles with any valid while full
module bsg_async_fifo_wr_arb
    import bsg_async_fifo_wr_arb_pkg::*;
#(
    parameter int unsigned reqs_p       = 4,
    parameter int unsigned data_width_p = 8
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic [reqs_p-1:0]                             v_i,
    input  logic [reqs_p*data_width_p-1:0]                data_i,
    input  logic [reqs_p-1:0]                             last_i,
    output logic [reqs_p-1:0]                             ready_o,
    output logic                                          w_enq_o,
    output logic [data_width_p+tag_width(reqs_p)-1:0]     w_data_o,
    input  logic                                          w_full_i,
`ifdef BSG_ASYNC_FIFO_WR_ARB_STALL_CNT_EN
    output logic [31:0]                                   stall_cnt_o,
`endif
    output logic                                          lock_v_o,
    output logic [tag_width(reqs_p)-1:0]                  lock_id_o
);

    localparam int unsigned tag_width_lp = tag_width(reqs_p);

    state_e                   state_q, state_d;
    logic [tag_width_lp-1:0]  ptr_q, ptr_d;
    logic [tag_width_lp-1:0]  lock_id_q, lock_id_d;

    logic                     pick_v;
    logic [tag_width_lp-1:0]  pick_id;
    logic                     grant_v;
    logic [tag_width_lp-1:0]  grant_id;
    logic [data_width_p-1:0]  grant_data;

    bsg_arb_rr_pick #(.reqs_p(reqs_p)) pick (
        .reqs_i (v_i),
        .ptr_i  (ptr_q),
        .v_o    (pick_v),
        .id_o   (pick_id)
    );

    // While locked the owner keeps the grant even when it bubbles.
    assign grant_v  = (state_q == e_lock) ? 1'b1 : pick_v;
    assign grant_id = (state_q == e_lock) ? lock_id_q : pick_id;

    // Grant decode, payload mux and next-state logic.
    always_comb begin
        ready_o    = '0;
        grant_data = '0;
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_id_d  = lock_id_q;

        for (int unsigned r = 0; r < reqs_p; r++) begin
            if (grant_id == tag_width_lp'(r)) begin
                ready_o[r] = grant_v & ~w_full_i & ~reset_i;
                grant_data = data_i[r*data_width_p +: data_width_p];
            end
        end

        w_enq_o = |(ready_o & v_i);

        if (w_enq_o) begin
            if (last_i[grant_id]) begin
                state_d   = e_idle;
                lock_id_d = '0;
                ptr_d     = (grant_id == tag_width_lp'(reqs_p - 1))
                          ? '0 : grant_id + tag_width_lp'(1);
            end else begin
                state_d   = e_lock;
                lock_id_d = grant_id;
            end
        end
    end

    assign w_data_o  = {grant_id, grant_data};
    assign lock_v_o  = (state_q == e_lock);
    assign lock_id_o = lock_id_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= e_idle;
            ptr_q     <= '0;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lock_id_q <= lock_id_d;
        end
    end

`ifdef BSG_ASYNC_FIFO_WR_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|v_i) && w_full_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert ($onehot0(ready_o));
            assert (!(w_enq_o && w_full_i));
            for (int unsigned r = 0; r < reqs_p; r++) begin
                assert (!((state_q == e_lock) && ready_o[r]
                          && (lock_id_q != tag_width_lp'(r))));
            end
        end
    end
`endif

endmodule
